// File: rtl/example01_y_pulse_logger_if.sv
// example01_y_pulse_logger_if: valid/ready stream of pulse-width records
//   out_valid  master->slave  head record present
//   out_width  master->slave  head record: pulse width in cycles
//   out_ready  slave->master  consumer accepts the head record
interface example01_y_pulse_logger_if #(parameter int CNT_W = 8);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_width;
    modport master(output out_valid, out_width, input out_ready);
    modport slave(input out_valid, out_width, output out_ready);
endinterface

// File: rtl/example01_y_pulse_logger.sv
// example01_y_pulse_logger: synchronises Y, measures its high pulses, queues width records
//   clk, rst       clock and asynchronous active-high reset
//   y_in           asynchronous Y input
//   clear          synchronous clear of FIFO, counters, overflow and FSM
//   rec            record stream (out_valid/out_width out, out_ready in)
//   rise_count     saturating count of y_sync rising edges
//   glitch_count   saturating count of pulses shorter than MIN_WIDTH
//   overflow       sticky: a record was dropped on a full FIFO
//   y_sync         synchronised Y
module example01_y_pulse_logger #(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_WIDTH  = 2,
    parameter int RISE_W     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                y_in,
    input  logic                                clear,
    example01_y_pulse_logger_if.master          rec,
    output logic [RISE_W-1:0]                   rise_count,
    output logic [7:0]                          glitch_count,
    output logic                                overflow,
    output logic                                y_sync
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, HIGH, DISCARD} state_t;
    state_t           state;
    logic             y_meta, y_prev;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
    logic [AW:0]      cnt, cnt_next;
    logic             rise, fin, push, pop, full, accept;
    assign rise     = y_sync & ~y_prev;
    assign fin      = state == HIGH && !y_sync;
    assign push     = fin && width >= CNT_W'(MIN_WIDTH);
    assign pop      = rec.out_valid & rec.out_ready;
    assign full     = cnt == (AW+1)'(FIFO_DEPTH);
    // a full FIFO still accepts when the head leaves in the same cycle
    assign accept   = push && (!full || pop);
    assign rd_next  = rd_ptr + AW'(pop);
    assign cnt_next = cnt + (AW+1)'(accept) - (AW+1)'(pop);
    // synchroniser and edge history are deliberately untouched by clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {y_meta, y_sync, y_prev} <= '0;
        else {y_meta, y_sync, y_prev} <= {y_in, y_meta, y_sync};
    end
    always_ff @(posedge clk) begin
        if (accept && !clear) mem[wr_ptr] <= width;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            width         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
            rec.out_valid <= 1'b0;
            rec.out_width <= '0;
            rise_count    <= '0;
            glitch_count  <= '0;
            overflow      <= 1'b0;
        end else if (clear) begin
            state         <= y_sync ? DISCARD : IDLE;
            width         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
            rec.out_valid <= 1'b0;
            rise_count    <= '0;
            glitch_count  <= '0;
            overflow      <= 1'b0;
        end else begin
            if (rise && rise_count != '1) rise_count <= rise_count + RISE_W'(1);
            if (fin && !push && glitch_count != 8'hff) glitch_count <= glitch_count + 8'd1;
            if (push && !accept) overflow <= 1'b1;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr        <= rd_next;
            cnt           <= cnt_next;
            rec.out_valid <= cnt_next != '0;
            // when the FIFO is empty after any pop, the new head is the record being pushed
            if (cnt_next != '0) rec.out_width <= (cnt == (AW+1)'(pop)) ? width : mem[rd_next];
            case (state)
                IDLE: begin
                    if (y_sync) begin
                        state <= HIGH;
                        width <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!y_sync) state <= IDLE;
                    else if (width != '1) width <= width + CNT_W'(1);
                end
                DISCARD: if (!y_sync) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_example01_y_pulse_logger.sv
// tb_example01_y_pulse_logger: directed bench with a queue-based reference model
module tb_example01_y_pulse_logger;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        y_in = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] rise_count;
    logic [7:0]  glitch_count;
    logic        overflow;
    logic        y_sync;
    int          total = 0;
    int          bad = 0;

    example01_y_pulse_logger_if #(.CNT_W(8)) bus ();

    example01_y_pulse_logger #(.CNT_W(8), .FIFO_DEPTH(4), .MIN_WIDTH(2), .RISE_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .y_in(y_in),
        .clear(clear),
        .rec(bus),
        .rise_count(rise_count),
        .glitch_count(glitch_count),
        .overflow(overflow),
        .y_sync(y_sync)
    );

    always #5 clk = ~clk;

    // Reference model: Y seen through a two-sample delay, pulses measured as run lengths
    int   q[$];
    logic m_s1 = 1'b0, m_sy = 1'b0, m_prev = 1'b0;
    int   run = 0, m_rc = 0, m_gc = 0;
    bit   disc = 1'b0, m_ov = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        bit so, fin, pop, full;
        int w;
        if (rst) begin
            q.delete();
            {m_s1, m_sy, m_prev} = 3'b000;
            run = 0; m_rc = 0; m_gc = 0; disc = 0; m_ov = 0;
        end else begin
            so = m_sy;
            w = run;
            fin = 0;
            if (clear) begin
                q.delete();
                m_rc = 0; m_gc = 0; m_ov = 0; run = 0;
                disc = so;
            end else begin
                if (so && !m_prev && m_rc < 65535) m_rc++;
                if (disc) begin
                    if (!so) disc = 0;
                end else if (so) begin
                    if (run < 255) run++;
                end else if (run > 0) begin
                    fin = 1;
                    run = 0;
                end
                pop = q.size() != 0 && bus.out_ready;
                full = q.size() == 4;
                if (pop) void'(q.pop_front());
                if (fin) begin
                    if (w < 2) begin
                        if (m_gc < 255) m_gc++;
                    end else if (full && !pop) m_ov = 1;
                    else q.push_back(w);
                end
            end
            m_prev = so;
            m_sy = m_s1;
            m_s1 = y_in;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_y_sync", 32'(y_sync), 32'(m_sy));
        chk("m_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("m_width", 32'(bus.out_width), q[0]);
        chk("m_rise", 32'(rise_count), m_rc);
        chk("m_glitch", 32'(glitch_count), m_gc);
        chk("m_overflow", 32'(overflow), 32'(m_ov));
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) cmp_model();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input int w);
        y_in = 1'b1;
        steps(w);
        y_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_rec(input int ew, input string n);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk({n, "_valid"}, 32'(bus.out_valid), 1);
        chk(n, 32'(bus.out_width), ew);
    endtask

    task automatic drain(input int e0, input int e1, input int e2, input int e3, input string n);
        int e[4];
        e = '{e0, e1, e2, e3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk({n, "_valid"}, 32'(bus.out_valid), 1);
            chk(n, 32'(bus.out_width), e[i]);
            step();
        end
        bus.out_ready = 1'b0;
        chk({n, "_empty"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_rise", 32'(rise_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        steps(2);
        rst = 1'b0;
        steps(2);
        // 1: single 5-cycle pulse
        bus.out_ready = 1'b1;
        pulse(5);
        wait_rec(5, "t1_width");
        chk("t1_rise", 32'(rise_count), 1);
        steps(3);
        // 2: 1-cycle glitch
        do_clear();
        pulse(1);
        steps(6);
        chk("t2_glitch", 32'(glitch_count), 1);
        chk("t2_rise", 32'(rise_count), 1);
        chk("t2_valid", 32'(bus.out_valid), 0);
        // 3: overflow with stalled consumer
        bus.out_ready = 1'b0;
        do_clear();
        for (int w = 3; w <= 7; w++) begin
            pulse(w);
            steps(4);
        end
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_rise", 32'(rise_count), 5);
        drain(3, 4, 5, 6, "t3_drain");
        chk("t3_overflow_kept", 32'(overflow), 1);
        // 4: push and pop together while full
        do_clear();
        for (int w = 2; w <= 5; w++) begin
            pulse(w);
            steps(4);
        end
        pulse(6);
        steps(2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        steps(3);
        chk("t4_overflow", 32'(overflow), 0);
        drain(3, 4, 5, 6, "t4_drain");
        // 5: width saturation
        do_clear();
        pulse(300);
        steps(5);
        chk("t5_valid", 32'(bus.out_valid), 1);
        chk("t5_width", 32'(bus.out_width), 255);
        bus.out_ready = 1'b1;
        steps(3);
        bus.out_ready = 1'b0;
        // 6: clear mid-pulse, then a 2-cycle pulse
        do_clear();
        y_in = 1'b1;
        steps(4);
        do_clear();
        steps(3);
        y_in = 1'b0;
        steps(6);
        chk("t6_valid", 32'(bus.out_valid), 0);
        chk("t6_rise", 32'(rise_count), 0);
        chk("t6_glitch", 32'(glitch_count), 0);
        pulse(2);
        steps(5);
        chk("t6_valid2", 32'(bus.out_valid), 1);
        chk("t6_width2", 32'(bus.out_width), 2);
        // reset mid-pulse, checked before any clock edge
        y_in = 1'b1;
        steps(4);
        #2 rst = 1'b1;
        #1;
        chk("r_valid", 32'(bus.out_valid), 0);
        chk("r_width", 32'(bus.out_width), 0);
        chk("r_rise", 32'(rise_count), 0);
        chk("r_glitch", 32'(glitch_count), 0);
        chk("r_overflow", 32'(overflow), 0);
        chk("r_y_sync", 32'(y_sync), 0);
        y_in = 1'b0;
        step();
        rst = 1'b0;
        steps(8);
        chk("r_no_record", 32'(bus.out_valid), 0);
        chk("r_rise_after", 32'(rise_count), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
